// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue in front of the register file
// write port. Results are buffered in a small FIFO and retired one per cycle
// through a registered output stage. Two lookup ports report the youngest
// value still pending for a register, so decode can forward uncommitted
// results.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_W-1:0]              in_reg,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           wr_hold,
    input  logic                           flush,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_reg,
    output logic [DATA_W-1:0]              wr_data,
    input  logic [ADDR_W-1:0]              chk_reg1,
    input  logic [ADDR_W-1:0]              chk_reg2,
    output logic                           chk_hit1,
    output logic                           chk_hit2,
    output logic [DATA_W-1:0]              chk_data1,
    output logic [DATA_W-1:0]              chk_data2,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // FIFO storage is data only; validity comes from the occupancy count.
    logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic accept;
    logic store;
    logic pop;

    // Handshake, pop decision and next-state for pointers, count and output stage.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        accept    = in_valid && in_ready && !flush;
        // Register 0 is hard-wired: the handshake completes but nothing is queued.
        store     = accept && (in_reg != '0);
        pop       = (count_q != '0) && !wr_hold && !flush;

        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = pop;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d    = head_q + PTR_W'(1);
                wr_reg_d  = mem_reg_q[head_q];
                wr_data_d = mem_data_q[head_q];
            end
            if (store) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO entry write at the tail; storage needs no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_reg_q[tail_q]  <= in_reg;
            mem_data_q[tail_q] <= in_data;
        end
    end

    // Control and output-stage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Pending-write lookup: output stage first, then FIFO oldest to youngest so
    // the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        chk_hit1  = 1'b0;
        chk_hit2  = 1'b0;
        chk_data1 = '0;
        chk_data2 = '0;

        if (wr_en_q && (wr_reg_q == chk_reg1)) begin
            chk_hit1  = 1'b1;
            chk_data1 = wr_data_q;
        end
        if (wr_en_q && (wr_reg_q == chk_reg2)) begin
            chk_hit2  = 1'b1;
            chk_data2 = wr_data_q;
        end

        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (mem_reg_q[idx] == chk_reg1) begin
                    chk_hit1  = 1'b1;
                    chk_data1 = mem_data_q[idx];
                end
                if (mem_reg_q[idx] == chk_reg2) begin
                    chk_hit2  = 1'b1;
                    chk_data2 = mem_data_q[idx];
                end
            end
        end

        if (chk_reg1 == '0) begin
            chk_hit1  = 1'b0;
            chk_data1 = '0;
        end
        if (chk_reg2 == '0) begin
            chk_hit2  = 1'b0;
            chk_data2 = '0;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model with a decoupled
// write-port scoreboard.
module tb_regfile_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              wr_hold;
    logic              flush;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] chk_reg1, chk_reg2;
    logic              chk_hit1, chk_hit2;
    logic [DATA_W-1:0] chk_data1, chk_data2;
    logic [$clog2(DEPTH+1)-1:0] count;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wr_hold(wr_hold), .flush(flush),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .chk_data1(chk_data1), .chk_data2(chk_data2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model: pending writes in program order, plus the write that
    // the register file sees during the current cycle.
    ent_t pend[$];
    ent_t exp_q[$];
    bit   out_v;
    ent_t out_e;
    ent_t mon_e;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_lookup(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (!hit && pend[i].r == a) begin
                    hit = 1'b1;
                    d   = pend[i].d;
                end
            end
            if (!hit && out_v && out_e.r == a) begin
                hit = 1'b1;
                d   = out_e.d;
            end
        end
    endtask

    // Scoreboard monitor: every register-file write must match the next
    // expected write, in order and in the expected cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_en_unexpected", {63'd0, wr_en}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_reg", {59'd0, wr_reg}, {59'd0, mon_e.r});
                check("wr_data", {32'd0, wr_data}, {32'd0, mon_e.d});
            end
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_en_missing", {63'd0, wr_en}, 64'd1);
        end
    end

    // One cycle: drive inputs, check combinational outputs against the model,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                        input bit h, input bit f,
                        input logic [ADDR_W-1:0] c1, input logic [ADDR_W-1:0] c2);
        logic              eh1, eh2;
        logic [DATA_W-1:0] ed1, ed2;
        bit                full;
        ent_t              e;
        @(negedge clk);
        in_valid = v; in_reg = r; in_data = d; wr_hold = h; flush = f;
        chk_reg1 = c1; chk_reg2 = c2;
        #1;
        full = (pend.size() == DEPTH);
        model_lookup(c1, eh1, ed1);
        model_lookup(c2, eh2, ed2);
        check("in_ready", {63'd0, in_ready}, {63'd0, !full});
        check("count", {61'd0, count}, 64'(pend.size()));
        check("chk_hit1", {63'd0, chk_hit1}, {63'd0, eh1});
        check("chk_data1", {32'd0, chk_data1}, {32'd0, ed1});
        check("chk_hit2", {63'd0, chk_hit2}, {63'd0, eh2});
        check("chk_data2", {32'd0, chk_data2}, {32'd0, ed2});
        if (f) begin
            pend.delete();
            out_v = 1'b0;
        end else begin
            if (pend.size() > 0 && !h) begin
                e = pend.pop_front();
                exp_q.push_back(e);
                out_v = 1'b1;
                out_e = e;
            end else begin
                out_v = 1'b0;
            end
            if (v && !full && r != '0) begin
                e = {r, d};
                pend.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
        check({tag, "_wr_reg"}, {59'd0, wr_reg}, 64'd0);
        check({tag, "_wr_data"}, {32'd0, wr_data}, 64'd0);
        check({tag, "_count"}, {61'd0, count}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_chk_hit1"}, {63'd0, chk_hit1}, 64'd0);
        check({tag, "_chk_hit2"}, {63'd0, chk_hit2}, 64'd0);
        check({tag, "_chk_data1"}, {32'd0, chk_data1}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0; wr_hold = 1'b0; flush = 1'b0;
        pend.delete();
        exp_q.delete();
        out_v = 1'b0;
        out_e = '0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_reg = '0; in_data = '0;
        wr_hold = 1'b0; flush = 1'b0;
        chk_reg1 = 5'd3; chk_reg2 = 5'd5;
        out_v = 1'b0; out_e = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_init");
        #1 rst_n = 1'b1;

        // Single write: latency and one-cycle pulse.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0);
        repeat (4) step(0, 5'd0, 32'h0, 0, 0, 5'd5, 5'd0);

        // Register zero is accepted but never queued.
        step(1, 5'd0, 32'h1234, 0, 0, 5'd0, 5'd0);
        repeat (3) step(0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0);

        // Backpressure: fill under hold, fifth offer refused, then drain in order.
        for (int i = 1; i <= 4; i++)
            step(1, 5'(i), 32'(i * 'h11), 1, 0, 5'(i), 5'd1);
        step(1, 5'd5, 32'h55, 1, 0, 5'd5, 5'd4);
        repeat (7) step(0, 5'd0, 32'h0, 0, 0, 5'd4, 5'd2);

        // Forwarding: youngest of two writes to r7 wins.
        step(1, 5'd7, 32'hA, 1, 0, 5'd8, 5'd7);
        step(1, 5'd7, 32'hB, 1, 0, 5'd8, 5'd7);
        step(0, 5'd0, 32'h0, 1, 0, 5'd8, 5'd7);
        repeat (4) step(0, 5'd0, 32'h0, 0, 0, 5'd8, 5'd7);

        // Flush with a concurrent offer: everything dropped.
        for (int i = 1; i <= 3; i++)
            step(1, 5'(9 + i), 32'(32'hF00 + i), 1, 0, 5'd10, 5'd12);
        step(1, 5'd9, 32'h99, 1, 1, 5'd10, 5'd9);
        repeat (4) step(0, 5'd0, 32'h0, 0, 0, 5'd10, 5'd9);

        // Reset with three entries queued.
        for (int i = 1; i <= 3; i++)
            step(1, 5'(20 + i), 32'(32'hC00 + i), 1, 0, 5'd21, 5'd23);
        chk_reg1 = 5'd21; chk_reg2 = 5'd23;
        do_reset();
        repeat (4) step(0, 5'd0, 32'h0, 0, 0, 5'd21, 5'd23);

        // Random traffic over a small register range to provoke lookup hits.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        repeat (8) step(0, 5'd0, 32'h0, 0, 0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("model_drained", {61'd0, count}, 64'(pend.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback-side driver for the 32x32 register file: accepts destination/result pairs from the execute and memory stages through a valid/ready handshake, buffers them in order in a small FIFO, and issues at most one register-file write per cycle on the `regwrite`/`writereg`/`writedata` port. A pending-write lookup on two read addresses lets the decode stage detect and forward results that are still queued and not yet committed. It sits between the pipeline result bus and the register file write port.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  result offered
- `in_ready`  out  1  queue can accept (combinational: count != DEPTH)
- `in_reg`  in  ADDR_W  destination register
- `in_data`  in  DATA_W  result value
- `wr_hold`  in  1  register file busy; no pop this cycle
- `flush`  in  1  synchronous discard of all pending writes
- `wr_en`  out  1  to register file `regwrite`, registered
- `wr_reg`  out  ADDR_W  to `writereg`, registered
- `wr_data`  out  DATA_W  to `writedata`, registered
- `chk_reg1`, `chk_reg2`  in  ADDR_W  lookup addresses (decode read operands)
- `chk_hit1`, `chk_hit2`  out  1  pending write to that register exists (combinational)
- `chk_data1`, `chk_data2`  out  DATA_W  youngest pending value, 0 when no hit
- `count`  out  clog2(DEPTH+1)  FIFO occupancy, excluding the output stage

## Operation
- Accept: `in_valid && in_ready && !flush`. If `in_reg == 0`, the handshake completes but nothing is stored (register 0 is never written).
- Pop: when FIFO non-empty, `!wr_hold`, `!flush` → head moves into output stage: `wr_en=1`, `wr_reg/wr_data` = head for exactly one cycle. Otherwise `wr_en=0` next cycle; `wr_reg/wr_data` hold last value.
- Strict FIFO order; no coalescing of writes to the same register.
- Simultaneous accept and pop when not full: both occur, count unchanged. When full, `in_ready=0` even if a pop occurs that cycle (no pass-through).
- Lookup: hit if `chk_regN != 0` and it matches any valid FIFO entry or the output stage while `wr_en=1`. Data priority: youngest FIFO entry (nearest tail), then older entries, then output stage.
- Flush: next edge empties FIFO, clears `wr_en`; takes priority over accept and pop; input offered that cycle is not stored (handshake still counted if `in_ready=1`, data dropped).
- Pointers wrap modulo DEPTH; occupancy tracked separately to distinguish full from empty.

## Timing
- Reset (async assert, sync-released use): `wr_en=0`, `wr_reg=0`, `wr_data=0`, `count=0`, FIFO empty, so `in_ready=1`, `chk_hit*=0`, `chk_data*=0`.
- Reset mid-operation discards all queued writes; none are issued.
- Latency: accept at edge N (empty, no hold) → `wr_en=1` in cycle after edge N+1 (2 cycles).
- Throughput: one write per cycle sustained while `wr_hold=0`.
- Lookup outputs reflect state after the most recent edge; an entry accepted in the current cycle is not visible until the next.

## Test plan
- Reset: assert `rst_n=0` mid-stream with 3 entries queued → all outputs 0, `in_ready=1`; after release no `wr_en` pulse occurs.
- Single write: accept (`in_reg=5`, `in_data=0xDEADBEEF`) at edge N → `wr_en=1`, `wr_reg=5`, `wr_data=0xDEADBEEF` in exactly the cycle after edge N+1; `wr_en=0` after.
- Register zero: offer `in_reg=0`, `in_data=0x1234` → `in_ready=1`, `count` stays 0, no `wr_en`; `chk_reg1=0` → `chk_hit1=0`.
- Backpressure: `wr_hold=1`, push regs 1,2,3,4 (data 0x11..0x44) → `count=4`, `in_ready=0`, 5th offer not accepted; release hold → four consecutive `wr_en` pulses in order 1,2,3,4 with matching data, `count` returns to 0.
- Forwarding: with hold, push (7,0xA), (7,0xB) → `chk_reg2=7` gives `chk_hit2=1`, `chk_data2=0xB`; `chk_reg1=8` gives hit 0, data 0.
- Flush: 3 entries queued, assert `flush` one cycle with a concurrent offer → next cycle `count=0`, `wr_en=0`, all `chk_hit*=0`, offered entry never written.
